// File: rtl/crc_host_pkg.sv
// crc_host_pkg: shared types and constants for the clk_1-side CRC job requester.
package crc_host_pkg;

    localparam int MSG_W = 60;

    localparam logic CRC_SEL_CRC8 = 1'b0;
    localparam logic CRC_SEL_CRC5 = 1'b1;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // A check-mode result is a failure whenever the engine reports any non-zero residue.
    function automatic logic check_failed(input logic mode, input logic [MSG_W-1:0] result);
        return (mode == MODE_CHK) && (|result);
    endfunction

endpackage

// File: rtl/crc_host_sync.sv
// crc_host_sync: pSTAGES-deep synchronizer for the engine done flag followed by a
// rising-edge detector that emits a registered one-cycle pulse in the clk_1 domain.
module crc_host_sync #(
    parameter int pSTAGES = 2
) (
    input  logic clk_1,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic [pSTAGES-1:0] r_sync;
    logic               r_prev;
    logic               r_pulse;

    // Parameter sanity: a single flop is not a synchronizer.
    generate
        if (pSTAGES < 2) begin : g_bad_stages
            $error("crc_host_sync: pSTAGES must be at least 2");
        end
    endgenerate

    // Shift the asynchronous flag through the synchronizer chain.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[pSTAGES-2:0], i_async};
        end
    end

    // Track the previous synchronized level and register the rising edge as a pulse.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= r_sync[pSTAGES-1];
            r_pulse <= r_sync[pSTAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/crc_host_ctrl.sv
// crc_host_ctrl: clk_1-side requester for the clk_2 CRC engine. Accepts one job,
// launches it with a pFLAG_CYCLES-wide flag, waits for the synchronized done pulse,
// captures the engine result and hands it downstream.
// Optional build macro: CRC_HOST_TIMEOUT_EN adds a WAIT watchdog of pTIMEOUT cycles.
module crc_host_ctrl
    import crc_host_pkg::*;
#(
    parameter int pSTAGES      = 2,
    parameter int pFLAG_CYCLES = 1,
    parameter int pTIMEOUT     = 1023
) (
    input  logic             clk_1,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [MSG_W-1:0] in_message,
    input  logic             in_CRC,
    input  logic             in_mode,
    output logic             in_ready,
    output logic [MSG_W-1:0] clk1_message,
    output logic             clk1_CRC,
    output logic             clk1_mode,
    output logic             clk1_flag,
    input  logic [MSG_W-1:0] clk2_out,
    input  logic             clk2_flag,
    output logic             out_valid,
    output logic [MSG_W-1:0] out_data,
    output logic             out_crc_fail,
    output logic             out_timeout,
    input  logic             out_ready
);

    localparam int FC_W = (pFLAG_CYCLES < 2) ? 1 : $clog2(pFLAG_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(pFLAG_CYCLES);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_launch_done;
    logic             w_edge;
    logic             w_edge_in_wait;
    logic             w_timeout_hit;
    logic [FC_W-1:0]  r_flag_cnt;
    logic             r_clk1_flag;
    logic [MSG_W-1:0] r_clk1_message;
    logic             r_clk1_crc;
    logic             r_clk1_mode;
    logic [MSG_W-1:0] r_out_data;
    logic             r_out_crc_fail;

    // Parameter sanity for the launch width and the watchdog limit.
    generate
        if (pFLAG_CYCLES < 1 || pTIMEOUT < 1) begin : g_bad_params
            $error("crc_host_ctrl: pFLAG_CYCLES and pTIMEOUT must be at least 1");
        end
    endgenerate

    crc_host_sync #(
        .pSTAGES (pSTAGES)
    ) u_sync (
        .clk_1   (clk_1),
        .rst_n   (rst_n),
        .i_async (clk2_flag),
        .o_pulse (w_edge)
    );

    // The detector keeps running in every state; only WAIT acts on its pulse.
    assign w_accept       = (r_state == ST_IDLE) && in_valid;
    assign w_launch_done  = (r_state == ST_LAUNCH) && (r_flag_cnt == FC_LAST);
    assign w_edge_in_wait = (r_state == ST_WAIT) && w_edge;

`ifdef CRC_HOST_TIMEOUT_EN
    localparam int TO_W = ($clog2(pTIMEOUT + 1) < 10) ? 10 : $clog2(pTIMEOUT + 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic            r_timeout;

    // Watchdog counter: cleared on WAIT entry, counts every WAIT cycle.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_launch_done) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
        end
    end

    // A done edge in the limit cycle takes priority over the watchdog.
    assign w_timeout_hit = (r_state == ST_WAIT) && !w_edge && (r_wait_cnt == TO_W'(pTIMEOUT));

    // Timeout flag travels with the captured result.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_edge_in_wait) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign out_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign out_timeout   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (r_flag_cnt == FC_LAST) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_edge || w_timeout_hit) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Job registers: loaded on acceptance, held until the next acceptance.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_clk1_message <= '0;
            r_clk1_crc     <= CRC_SEL_CRC8;
            r_clk1_mode    <= MODE_GEN;
        end else if (w_accept) begin
            r_clk1_message <= in_message;
            r_clk1_crc     <= in_CRC;
            r_clk1_mode    <= in_mode;
        end
    end

    // Launch flag is a flop so the engine sees a glitch-free pulse of pFLAG_CYCLES cycles.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_clk1_flag <= 1'b0;
            r_flag_cnt  <= '0;
        end else if (w_accept) begin
            r_clk1_flag <= 1'b1;
            r_flag_cnt  <= FC_W'(1);
        end else if (r_state == ST_LAUNCH) begin
            if (w_launch_done) begin
                r_clk1_flag <= 1'b0;
            end else begin
                r_flag_cnt <= r_flag_cnt + FC_W'(1);
            end
        end
    end

    // Result capture: only WAIT updates the outputs, so they hold throughout RESP.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data     <= '0;
            r_out_crc_fail <= 1'b0;
        end else if (w_edge_in_wait) begin
            r_out_data     <= clk2_out;
            r_out_crc_fail <= check_failed(r_clk1_mode, clk2_out);
        end else if (w_timeout_hit) begin
            r_out_data     <= '0;
            r_out_crc_fail <= 1'b0;
        end
    end

    assign clk1_message = r_clk1_message;
    assign clk1_CRC     = r_clk1_crc;
    assign clk1_mode    = r_clk1_mode;
    assign clk1_flag    = r_clk1_flag;
    assign out_data     = r_out_data;
    assign out_crc_fail = r_out_crc_fail;

endmodule

// File: tb/tb_crc_host_ctrl.sv
// tb_crc_host_ctrl: table-driven bench for crc_host_ctrl with a clk_2 engine stub
// that raises clk2_flag for 3 cycles, 30 cycles after it samples clk1_flag high.
// Timeout sequences are compiled in when CRC_HOST_TIMEOUT_EN is defined.
module tb_crc_host_ctrl;

    localparam int P_STAGES = 2;
    localparam int P_FLAG   = 2;
    localparam int P_TO     = 60;
    localparam int STUB_DLY = 30;
    // Edges from acceptance to out_valid: stub samples the flag one edge after
    // acceptance, then 30 cycles, then pSTAGES+2 more cycles to out_valid.
    localparam int EXP_LAT  = 1 + STUB_DLY + P_STAGES + 2;
    // Watchdog: WAIT entered P_FLAG edges after acceptance, fires when count reaches P_TO.
    localparam int TO_LAT   = P_FLAG + P_TO + 1;
    localparam logic [59:0] ONES = {60{1'b1}};

    logic        clk_1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [59:0] in_message = '0;
    logic        in_CRC = 1'b0;
    logic        in_mode = 1'b0;
    logic        in_ready;
    logic [59:0] clk1_message;
    logic        clk1_CRC;
    logic        clk1_mode;
    logic        clk1_flag;
    logic [59:0] clk2_out;
    logic        clk2_flag;
    logic        out_valid;
    logic [59:0] out_data;
    logic        out_crc_fail;
    logic        out_timeout;
    logic        out_ready = 1'b0;

    logic        stub_en = 1'b0;
    logic [59:0] stub_data = '0;
    logic        stub_flag = 1'b0;
    logic        manual_flag = 1'b0;
    int          stub_cnt = -1;
    int          stub_hi = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    crc_host_ctrl #(
        .pSTAGES      (P_STAGES),
        .pFLAG_CYCLES (P_FLAG),
        .pTIMEOUT     (P_TO)
    ) dut (
        .clk_1        (clk_1),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_message   (in_message),
        .in_CRC       (in_CRC),
        .in_mode      (in_mode),
        .in_ready     (in_ready),
        .clk1_message (clk1_message),
        .clk1_CRC     (clk1_CRC),
        .clk1_mode    (clk1_mode),
        .clk1_flag    (clk1_flag),
        .clk2_out     (clk2_out),
        .clk2_flag    (clk2_flag),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_crc_fail (out_crc_fail),
        .out_timeout  (out_timeout),
        .out_ready    (out_ready)
    );

    always #5 clk_1 = ~clk_1;

    assign clk2_out  = stub_data;
    assign clk2_flag = stub_flag | manual_flag;

    // Engine stub: sample clk1_flag, wait STUB_DLY cycles, hold the done flag 3 cycles.
    always @(posedge clk_1) begin
        if (!rst_n || !stub_en) begin
            stub_cnt = -1;
            stub_hi  = 0;
            #1 stub_flag = 1'b0;
        end else if (stub_hi > 0) begin
            stub_hi--;
            if (stub_hi == 0) begin
                #1 stub_flag = 1'b0;
            end
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                stub_cnt = -1;
                stub_hi  = 3;
                #1 stub_flag = 1'b1;
            end
        end else if (clk1_flag) begin
            stub_cnt = STUB_DLY;
        end
    end

    typedef struct {
        string       name;
        logic [59:0] msg;
        logic        crc;
        logic        mode;
        logic [59:0] eng;
        logic [59:0] exp_data;
        logic        exp_fail;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    // Present a job for one edge and check the launch-side outputs right after acceptance.
    task automatic accept(input string nm, input logic [59:0] msg, input logic crc, input logic mode);
        in_message = msg;
        in_CRC     = crc;
        in_mode    = mode;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        chk({nm, "_accept_flag"}, 64'(clk1_flag), 64'd1);
        chk({nm, "_accept_ready"}, 64'(in_ready), 64'd0);
        chk({nm, "_accept_msg"}, 64'(clk1_message), 64'(msg));
        chk({nm, "_accept_sel"}, 64'({clk1_CRC, clk1_mode}), 64'({crc, mode}));
    endtask

    // Count edges after acceptance until out_valid; optionally inject a manual done pulse.
    task automatic wait_result(input string nm, input int manual_at, output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            if (lat == manual_at) manual_flag = 1'b1;
            if (lat == manual_at + 3) manual_flag = 1'b0;
            tick();
            lat++;
            if (lat == P_FLAG) chk({nm, "_flag_width"}, 64'(clk1_flag), 64'd0);
        end
        manual_flag = 1'b0;
        if (!out_valid) chk({nm, "_wait_bound"}, 64'(out_valid), 64'd1);
    endtask

    task automatic release_result(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_turnaround_ready"}, 64'(in_ready), 64'd1);
        chk({nm, "_turnaround_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic [59:0] held;

        vecs[0] = '{"crc5_gen", 60'h0123456789ABCDE, 1'b1, 1'b0, 60'h0F0F0F0F0F0F0F0, 60'h0F0F0F0F0F0F0F0, 1'b0};
        vecs[1] = '{"crc8_chk_fail", 60'hFEDCBA987654321, 1'b0, 1'b1, ONES, ONES, 1'b1};
        vecs[2] = '{"crc8_chk_pass", 60'h5A5A5A5A5A5A5A5, 1'b0, 1'b1, 60'h0, 60'h0, 1'b0};
        vecs[3] = '{"crc8_gen", 60'h00000000ABCDEF1, 1'b0, 1'b0, 60'h0000ABCDEF1A5C3, 60'h0000ABCDEF1A5C3, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flag", 64'(clk1_flag), 64'd0);
        chk("rst_msg", 64'(clk1_message), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_misc", 64'({clk1_CRC, clk1_mode, out_crc_fail, out_timeout}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven jobs
        stub_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stub_data = vecs[i].eng;
            accept(vecs[i].name, vecs[i].msg, vecs[i].crc, vecs[i].mode);
            wait_result(vecs[i].name, -1, lat);
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'(EXP_LAT));
            chk({vecs[i].name, "_data"}, 64'(out_data), 64'(vecs[i].exp_data));
            chk({vecs[i].name, "_fail"}, 64'(out_crc_fail), 64'(vecs[i].exp_fail));
            chk({vecs[i].name, "_timeout"}, 64'(out_timeout), 64'd0);
            chk({vecs[i].name, "_busy"}, 64'(in_ready), 64'd0);
            release_result(vecs[i].name);
            chk({vecs[i].name, "_msg_held"}, 64'(clk1_message), 64'(vecs[i].msg));
        end

        // Back-pressure: outputs hold, new jobs ignored
        stub_data = 60'h123456789ABCDEF;
        accept("hold", 60'h0AAAAAAAAAAAAAA, 1'b1, 1'b0);
        wait_result("hold", -1, lat);
        held = out_data;
        chk("hold_data_first", 64'(held), 64'h123456789ABCDEF);
        for (int k = 0; k < 10; k++) begin
            in_valid   = k[0];
            in_message = 60'h0BBBBBBBBBBBBBB;
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(held));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        chk("hold_msg_unchanged", 64'(clk1_message), 64'h0AAAAAAAAAAAAAA);
        release_result("hold");

        // Spurious done pulse in IDLE is ignored
        stub_en   = 1'b0;
        stub_data = 60'h0DEADBEEF000000;
        manual_flag = 1'b1;
        tick();
        tick();
        tick();
        manual_flag = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("spur_no_valid", 64'(out_valid), 64'd0);
        chk("spur_ready", 64'(in_ready), 64'd1);
        stub_en   = 1'b1;
        stub_data = 60'h0C0FFEE12345678;
        accept("spur", 60'h0111111111111111 & 60'hFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        wait_result("spur", -1, lat);
        chk("spur_latency", 64'(lat), 64'(EXP_LAT));
        chk("spur_data", 64'(out_data), 64'h0C0FFEE12345678);
        release_result("spur");

        // Reset asserted in WAIT
        stub_data = ONES;
        accept("rstwait", 60'h0999999999999999 & 60'hFFFFFFFFFFFFFFF, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("rstwait_in_ready", 64'(in_ready), 64'd1);
        chk("rstwait_flag_msg", 64'({clk1_flag, clk1_message}), 64'd0);
        chk("rstwait_out", 64'({out_valid, out_crc_fail, out_timeout}), 64'd0);
        chk("rstwait_out_data", 64'(out_data), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        stub_data = 60'h0F0F0F0F0F0F0F0;
        accept("after_rst", 60'h0123456789ABCDE, 1'b1, 1'b0);
        wait_result("after_rst", -1, lat);
        chk("after_rst_latency", 64'(lat), 64'(EXP_LAT));
        chk("after_rst_data", 64'(out_data), 64'h0F0F0F0F0F0F0F0);
        release_result("after_rst");

`ifdef CRC_HOST_TIMEOUT_EN
        // Silent engine: watchdog returns a timeout result
        stub_en   = 1'b0;
        stub_data = 60'h0777777777777777 & 60'hFFFFFFFFFFFFFFF;
        accept("wdog", 60'h0246813579ACE02, 1'b0, 1'b1);
        wait_result("wdog", -1, lat);
        chk("wdog_latency", 64'(lat), 64'(TO_LAT));
        chk("wdog_timeout", 64'(out_timeout), 64'd1);
        chk("wdog_data", 64'(out_data), 64'd0);
        chk("wdog_fail", 64'(out_crc_fail), 64'd0);
        release_result("wdog");

        // Done edge lands on the limit cycle: normal result wins
        stub_data = ONES;
        accept("wdog_tie", 60'h0246813579ACE02, 1'b0, 1'b1);
        wait_result("wdog_tie", TO_LAT - P_STAGES - 2, lat);
        chk("wdog_tie_latency", 64'(lat), 64'(TO_LAT));
        chk("wdog_tie_timeout", 64'(out_timeout), 64'd0);
        chk("wdog_tie_data", 64'(out_data), 64'(ONES));
        chk("wdog_tie_fail", 64'(out_crc_fail), 64'd1);
        release_result("wdog_tie");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/crc_host_ctrl.md
# crc_host_ctrl

Single-clock requester on the clk_1 side of the CRC engine interface. It accepts one CRC job at a time from upstream via a valid/ready handshake, presents it to the clk_2 CRC engine (`clk1_*` signals), and waits for the engine's `clk2_flag` completion pulse through an internal synchronizer. It then captures `clk2_out` and returns the result downstream via a second valid/ready handshake.

## Interface
- pSTAGES, 2: synchronizer flip-flop count on `clk2_flag` (≥2).
- pFLAG_CYCLES, 1: width in clk_1 cycles of the `clk1_flag` launch pulse. Chosen by the integrator so that exactly one engine edge samples it.
- pTIMEOUT, 1023: WAIT watchdog limit in clk_1 cycles (used only with the timeout feature).
- clk_1  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream job valid.
- in_message  in  60  message (generate: payload in low bits; check: codeword).
- in_CRC  in  1  0 = CRC-8, 1 = CRC-5.
- in_mode  in  1  0 = generate, 1 = check.
- in_ready  out  1  block can accept a job.
- clk1_message  out  60  job message to engine.
- clk1_CRC  out  1  job CRC select to engine.
- clk1_mode  out  1  job mode to engine.
- clk1_flag  out  1  launch pulse to engine.
- clk2_out  in  60  engine result, stable after its done pulse.
- clk2_flag  in  1  engine done pulse (asynchronous to clk_1).
- out_valid  out  1  result valid.
- out_data  out  60  captured result.
- out_crc_fail  out  1  check mode only: `out_data` ≠ 0; otherwise 0.
- out_timeout  out  1  result produced by the watchdog.
- out_ready  in  1  downstream accepts the result.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch message/CRC/mode into the `clk1_*` registers and go to LAUNCH.
- LAUNCH:
  - `clk1_flag` = 1 for exactly pFLAG_CYCLES cycles (counter), then go to WAIT.
- WAIT:
  - On a detected rising edge of synchronized `clk2_flag`, capture `clk2_out` into `out_data`.
  - Set `out_crc_fail` = `clk1_mode` & (|`clk2_out`). Go to RESP.
- RESP:
  - `out_valid` = 1.
  - On `out_ready`, go to IDLE.
- `clk1_message`/`clk1_CRC`/`clk1_mode` are held unchanged from acceptance until the next acceptance.
- Edges of `clk2_flag` are ignored outside WAIT. The edge detector still tracks the signal, so a pulse straddling the LAUNCH→WAIT transition is not double-counted.
- Generate result format is set by the engine: CRC-5 {msg[54:0], crc[4:0]}, CRC-8 {msg[51:0], crc[7:0]}. Check result is all-ones (fail) or all-zeros (pass).

## Timing
- Reset values:
  - `in_ready` = 1 (IDLE).
  - All other outputs 0, including `clk1_message`, `out_data`, `clk1_flag`.
  - Synchronizer flops 0; state IDLE.
- Acceptance at edge T → `clk1_flag` high on cycles T+1 … T+pFLAG_CYCLES.
- `in_ready` deasserts the cycle after acceptance.
- Engine done → edge detected pSTAGES+1 clk_1 cycles after `clk2_flag` is first sampled high.
- `out_valid` rises the cycle after detection.
- `out_valid` with `out_ready` at edge R → `in_ready` = 1 at R+1. No same-cycle turnaround.
- Outputs `out_*` hold while `out_valid` && !`out_ready`.
- `clk2_flag` pulse must span ≥1 clk_1 period plus setup. The integrator guarantees this.
- Reset asserted mid-job: immediate return to IDLE, `clk1_flag` drops asynchronously, and the in-flight result is discarded.

## Configuration
- CRC_HOST_TIMEOUT_EN defined:
  - A 10-bit+ counter clears on WAIT entry and increments each WAIT cycle.
  - At count == pTIMEOUT with no edge: go to RESP with `out_timeout` = 1, `out_data` = 0, `out_crc_fail` = 0.
  - If the edge and the limit occur in the same cycle, the edge wins.
- Undefined: WAIT is unbounded, no counter is present, and `out_timeout` is tied to 0.

## Structure
- Package `crc_host_pkg`: state enum, MSG_W = 60, CRC_SEL_CRC8 = 0 / CRC_SEL_CRC5 = 1, MODE_GEN = 0 / MODE_CHK = 1.
- Sub-module `crc_host_sync`: pSTAGES flop chain plus rising-edge detector, one-cycle pulse output, async active-low reset.

## Test plan
- Bench uses an engine stub that asserts `clk2_flag` for 3 cycles, 30 cycles after sampling `clk1_flag`.
- CRC-5 generate: msg 60'h0123456789ABCDE, stub returns 60'h0F0F0F0F0F0F0F0 → `out_data` = 60'h0F0F0F0F0F0F0F0, `out_crc_fail` = 0, `out_valid` 30+pSTAGES+2 cycles after launch.
- CRC-8 check, stub returns all-ones → `out_crc_fail` = 1; stub returns 0 → `out_crc_fail` = 0.
- `out_ready` held low 10 cycles → `out_valid`/`out_data` stable; `in_valid` pulses ignored, `in_ready` = 0 throughout.
- Spurious `clk2_flag` pulse in IDLE, then a job → result taken only from the post-launch pulse.
- Reset asserted during WAIT → all outputs at reset values, `in_ready` = 1; next job completes normally.
- With CRC_HOST_TIMEOUT_EN, stub silent → `out_timeout` = 1, `out_data` = 0 after pTIMEOUT WAIT cycles; edge on the limit cycle → normal result, `out_timeout` = 0.
